// File: rtl/sys_cmd_host.sv
// sys_cmd_host: command-frame source for the system serial RX input.
// Accepts one parallel command and turns it into the byte sequence the
// system controller decodes, then sends each byte as a UART frame:
// start, 8 data bits LSB first, optional parity, stop. One bit per clock.
//
// Ports
//   i_clk, i_rst_n         bit clock, async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake (ready only in IDLE)
//   i_cmd_type             00 REG_WR, 01 REG_RD, 10 ALU_OP, 11 ALU_NOP
//   i_addr, i_data_a/b     address and operands
//   i_alu_fun              ALU function code
//   i_par_en, i_par_typ    parity enable / odd (1) or even (0)
//   i_inj_par_err          (CMD_PAR_ERR_INJ_EN only) flip parity of last byte
//   o_tx_serial            serial line, idles high
//   o_busy                 command in flight
//   o_byte_done            pulse while each stop bit is on the line
//   o_cmd_done             pulse in the cycle after the last stop bit
//
// Optional feature: define CMD_PAR_ERR_INJ_EN to add parity error injection.
module sys_cmd_host #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int IDLE_GAP   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [1:0]            i_cmd_type,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data_a,
   input  logic [DATA_WIDTH-1:0] i_data_b,
   input  logic [3:0]            i_alu_fun,
   input  logic                  i_par_en,
   input  logic                  i_par_typ,
`ifdef CMD_PAR_ERR_INJ_EN
   input  logic                  i_inj_par_err,
`endif
   output logic                  o_tx_serial,
   output logic                  o_busy,
   output logic                  o_byte_done,
   output logic                  o_cmd_done
);

   if (ADDR_WIDTH > 8) begin : g_bad_addr
      $error("sys_cmd_host: ADDR_WIDTH must not exceed 8");
   end
   if (DATA_WIDTH != 8) begin : g_bad_data
      $error("sys_cmd_host: DATA_WIDTH must be 8 for UART framing");
   end
   if (IDLE_GAP < 0 || IDLE_GAP > 15) begin : g_bad_gap
      $error("sys_cmd_host: IDLE_GAP must be in 0..15");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

   state_t                     state;
   logic [3:0][DATA_WIDTH-1:0] byte_buf;
   logic [2:0]                 len;
   logic [1:0]                 byte_idx;
   logic [2:0]                 bit_cnt;
   logic [3:0]                 gap_cnt;
   logic                       par_en_q;
   logic                       par_typ_q;
   logic                       inj_q;

   logic [DATA_WIDTH-1:0] addr_byte;
   logic [DATA_WIDTH-1:0] fun_byte;
   logic [DATA_WIDTH-1:0] cur_byte;
   logic                  last_byte;
   logic                  par_bit;

   assign addr_byte = DATA_WIDTH'(i_addr);
   assign fun_byte  = DATA_WIDTH'(i_alu_fun);
   assign cur_byte  = byte_buf[byte_idx];
   assign last_byte = ({1'b0, byte_idx} == (len - 3'd1));
   // Injection only ever touches the final byte, so the receiver sees one
   // clean header and a corrupt tail.
   assign par_bit   = (^cur_byte) ^ par_typ_q ^ (inj_q & last_byte);

`ifndef CMD_PAR_ERR_INJ_EN
   assign inj_q = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         byte_buf    <= '0;
         len         <= '0;
         byte_idx    <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
`ifdef CMD_PAR_ERR_INJ_EN
         inj_q       <= 1'b0;
`endif
         o_tx_serial <= 1'b1;
         o_cmd_ready <= 1'b1;
         o_busy      <= 1'b0;
         o_byte_done <= 1'b0;
         o_cmd_done  <= 1'b0;
      end else begin
         o_byte_done <= 1'b0;
         o_cmd_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  byte_buf <= '0;
                  case (i_cmd_type)
                     2'b00: begin
                        byte_buf[0] <= DATA_WIDTH'(8'hAA);
                        byte_buf[1] <= addr_byte;
                        byte_buf[2] <= i_data_a;
                        len         <= 3'd3;
                     end
                     2'b01: begin
                        byte_buf[0] <= DATA_WIDTH'(8'hBB);
                        byte_buf[1] <= addr_byte;
                        len         <= 3'd2;
                     end
                     2'b10: begin
                        byte_buf[0] <= DATA_WIDTH'(8'hCC);
                        byte_buf[1] <= i_data_a;
                        byte_buf[2] <= i_data_b;
                        byte_buf[3] <= fun_byte;
                        len         <= 3'd4;
                     end
                     default: begin
                        byte_buf[0] <= DATA_WIDTH'(8'hDD);
                        byte_buf[1] <= fun_byte;
                        len         <= 3'd2;
                     end
                  endcase
                  par_en_q    <= i_par_en;
                  par_typ_q   <= i_par_typ;
`ifdef CMD_PAR_ERR_INJ_EN
                  inj_q       <= i_inj_par_err;
`endif
                  byte_idx    <= '0;
                  bit_cnt     <= '0;
                  gap_cnt     <= '0;
                  state       <= START;
                  o_tx_serial <= 1'b0;
                  o_cmd_ready <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            START: begin
               state       <= DATA;
               bit_cnt     <= '0;
               o_tx_serial <= cur_byte[0];
            end
            DATA: begin
               // bit_cnt names the bit currently on the line
               if (bit_cnt == 3'd7) begin
                  bit_cnt <= '0;
                  if (par_en_q) begin
                     state       <= PARITY;
                     o_tx_serial <= par_bit;
                  end else begin
                     state       <= STOP;
                     o_tx_serial <= 1'b1;
                     o_byte_done <= 1'b1;
                  end
               end else begin
                  bit_cnt     <= bit_cnt + 3'd1;
                  o_tx_serial <= cur_byte[bit_cnt + 3'd1];
               end
            end
            PARITY: begin
               state       <= STOP;
               o_tx_serial <= 1'b1;
               o_byte_done <= 1'b1;
            end
            STOP: begin
               if (last_byte) begin
                  state       <= IDLE;
                  o_tx_serial <= 1'b1;
                  o_cmd_ready <= 1'b1;
                  o_busy      <= 1'b0;
                  o_cmd_done  <= 1'b1;
               end else begin
                  byte_idx <= byte_idx + 2'd1;
                  if (IDLE_GAP > 0) begin
                     state       <= GAP;
                     gap_cnt     <= '0;
                     o_tx_serial <= 1'b1;
                  end else begin
                     state       <= START;
                     o_tx_serial <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt     <= '0;
                  state       <= START;
                  o_tx_serial <= 1'b0;
               end else begin
                  gap_cnt     <= gap_cnt + 4'd1;
                  o_tx_serial <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               o_tx_serial <= 1'b1;
               o_cmd_ready <= 1'b1;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cmd_host.sv
// Testbench for sys_cmd_host: scoreboard of expected frames and command
// completion times built from the command encoding rules, checked by a
// UART-receiver style monitor on the serial line.
module tb_sys_cmd_host;

   localparam int GAP = 1;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_cmd_valid = 1'b0;
   logic [1:0] i_cmd_type = '0;
   logic [3:0] i_addr = '0;
   logic [7:0] i_data_a = '0;
   logic [7:0] i_data_b = '0;
   logic [3:0] i_alu_fun = '0;
   logic       i_par_en = 1'b0;
   logic       i_par_typ = 1'b0;
`ifdef CMD_PAR_ERR_INJ_EN
   logic       i_inj_par_err = 1'b0;
`endif
   logic       o_cmd_ready, o_tx_serial, o_busy, o_byte_done, o_cmd_done;

   sys_cmd_host #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .IDLE_GAP(GAP)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready), .i_cmd_type(i_cmd_type), .i_addr(i_addr),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .i_alu_fun(i_alu_fun),
      .i_par_en(i_par_en), .i_par_typ(i_par_typ),
`ifdef CMD_PAR_ERR_INJ_EN
      .i_inj_par_err(i_inj_par_err),
`endif
      .o_tx_serial(o_tx_serial), .o_busy(o_busy),
      .o_byte_done(o_byte_done), .o_cmd_done(o_cmd_done));

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      bit         has_par;
      bit         par;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Receiver: position 0 = waiting for start, 1..8 data, 9 parity or stop.
   int         mpos = 0;
   exp_t       cur;
   logic [7:0] rx;
   logic       rxp;
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         mpos = 0;
      end else begin
         if (o_cmd_done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_cmd_done", 1, 0);
            end else begin
               chk("cmd_done_cycle", cyc, done_q.pop_front());
               chk("ready_at_done", o_cmd_ready, 1);
               chk("busy_low_at_done", o_busy, 0);
            end
         end
         if (mpos == 0) begin
            if (o_tx_serial === 1'b0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_start_bit", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("busy_in_frame", o_busy, 1);
                  mpos = 1;
               end
            end
         end else if (mpos <= 8) begin
            rx[mpos-1] = o_tx_serial;
            mpos++;
         end else if (mpos == 9 && cur.has_par) begin
            rxp = o_tx_serial;
            mpos = 10;
         end else begin
            chk("frame_byte", rx, cur.b);
            if (cur.has_par) chk("parity_bit", rxp, cur.par);
            chk("stop_bit", o_tx_serial, 1);
            chk("byte_done_at_stop", o_byte_done, 1);
            mpos = 0;
         end
      end
   end

   // Build the byte list for one command and queue the expectations.
   task automatic send(input logic [1:0] typ, input logic [3:0] addr,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fun, input bit pe, input bit pt,
                       input bit inj);
      logic [7:0] bytes[4];
      int         n;
      int         w;
      exp_t       e;
      case (typ)
         2'b00: begin bytes[0] = 8'hAA; bytes[1] = {4'h0, addr}; bytes[2] = a; n = 3; end
         2'b01: begin bytes[0] = 8'hBB; bytes[1] = {4'h0, addr}; n = 2; end
         2'b10: begin bytes[0] = 8'hCC; bytes[1] = a; bytes[2] = b; bytes[3] = {4'h0, fun}; n = 4; end
         default: begin bytes[0] = 8'hDD; bytes[1] = {4'h0, fun}; n = 2; end
      endcase
      i_cmd_type = typ; i_addr = addr; i_data_a = a; i_data_b = b;
      i_alu_fun = fun; i_par_en = pe; i_par_typ = pt;
`ifdef CMD_PAR_ERR_INJ_EN
      i_inj_par_err = inj;
`endif
      i_cmd_valid = 1'b1;
      w = 0;
      while (!o_cmd_ready && w < 400) begin
         @(negedge i_clk);
         w++;
      end
      if (!o_cmd_ready) begin
         chk("accept_timeout", 0, 1);
         i_cmd_valid = 1'b0;
         return;
      end
      // Accept happens on the coming rising edge.
      for (int i = 0; i < n; i++) begin
         e.b = bytes[i];
         e.has_par = pe;
         e.par = (^bytes[i]) ^ pt;
`ifdef CMD_PAR_ERR_INJ_EN
         if (inj && i == n - 1) e.par = ~e.par;
`endif
         exp_q.push_back(e);
      end
      done_q.push_back(cyc + 1 + n * (pe ? 11 : 10) + (n - 1) * GAP);
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      // Scramble inputs: the command in flight must not follow them.
      i_cmd_type = 2'($urandom); i_addr = 4'($urandom); i_data_a = 8'($urandom);
      i_data_b = 8'($urandom); i_alu_fun = 4'($urandom);
      i_par_en = 1'($urandom); i_par_typ = 1'($urandom);
      chk("busy_after_accept", o_busy, 1);
      chk("ready_low_after_accept", o_cmd_ready, 0);
   endtask

   task automatic drain();
      int w = 0;
      while (done_q.size() != 0 && w < 3000) begin
         @(negedge i_clk);
         w++;
      end
      chk("drain_done_queue", done_q.size(), 0);
      chk("drain_frame_queue", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);
      chk("reset_tx", o_tx_serial, 1);
      chk("reset_ready", o_cmd_ready, 1);
      chk("reset_busy", o_busy, 0);
      chk("reset_byte_done", o_byte_done, 0);
      chk("reset_cmd_done", o_cmd_done, 0);

      // Directed cases
      send(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();
      send(2'b10, 4'h0, 8'h12, 8'h34, 4'h2, 1'b1, 1'b0, 1'b0);
      drain();
      send(2'b01, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0);
      drain();
      send(2'b11, 4'h0, 8'h00, 8'h00, 4'h1, 1'b1, 1'b0, 1'b1);
      drain();

      // Reset in the middle of the second byte of a REG_WR
      send(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
      repeat (14) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("midreset_tx", o_tx_serial, 1);
      chk("midreset_ready", o_cmd_ready, 1);
      chk("midreset_busy", o_busy, 0);
      exp_q.delete();
      done_q.delete();
      repeat (2) @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      @(negedge i_clk);
      send(2'b01, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0);
      drain();

      // Back-to-back pair: second request held while the first is busy
      send(2'b11, 4'h0, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 1'b0);
      send(2'b10, 4'h0, 8'hFF, 8'h81, 4'hF, 1'b1, 1'b1, 1'b0);
      drain();

      // Randomized commands
      for (int k = 0; k < 24; k++) begin
         send(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
      drain();

      repeat (3) @(negedge i_clk);
      chk("final_idle_tx", o_tx_serial, 1);
      chk("final_idle_ready", o_cmd_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
